prbs7_checker: RTL and testbench

PRBS7_CHECKER -- requirements
Module: prbs7_checker

---
 rtl/prbs7_checker.sv | 143 ++++++++++++++
 tb/tb_prbs7_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// PRBS7 (x^7 + x^6 + 1, XNOR form) receive checker.
// Locks onto the incoming stream, then counts bit errors and compared bits.
module prbs7_checker #(
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned MatchW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned MissW  = $clog2(UNLOCK_COUNT + 1);
  localparam logic [MatchW-1:0] MatchLast = MatchW'(LOCK_COUNT - 1);
  localparam logic [MissW-1:0]  MissLast  = MissW'(UNLOCK_COUNT - 1);
  localparam logic [6:0] Lockup = 7'h7F;

  typedef enum logic [1:0] {StFill, StVerify, StLock} state_e;

  state_e             state_q, state_d;
  logic [6:0]         sr_q, sr_d;
  logic [2:0]         fill_cnt_q, fill_cnt_d;
  logic [MatchW-1:0]  match_run_q, match_run_d;
  logic [MissW-1:0]   miss_run_q, miss_run_d;
  logic               locked_q, locked_d;
  logic               err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;

  logic       pred;
  logic       hit;
  logic [6:0] sr_in;

  assign pred  = ~(sr_q[6] ^ sr_q[5]);
  assign hit   = (bit_in == pred);
  assign sr_in = {sr_q[5:0], bit_in};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    fill_cnt_d  = fill_cnt_q;
    match_run_d = match_run_q;
    miss_run_d  = miss_run_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    if (bit_valid) begin
      unique case (state_q)
        StFill: begin
          sr_d = sr_in;
          if (fill_cnt_q == 3'd6) begin
            fill_cnt_d = 3'd0;
            // An all-ones register is the XNOR lockup state; refill instead.
            if (sr_in != Lockup) begin
              state_d     = StVerify;
              match_run_d = '0;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 3'd1;
          end
        end
        StVerify: begin
          sr_d = sr_in;
          if (hit && (sr_in != Lockup)) begin
            if (match_run_q == MatchLast) begin
              state_d     = StLock;
              match_run_d = '0;
              miss_run_d  = '0;
            end else begin
              match_run_d = match_run_q + MatchW'(1);
            end
          end else begin
            match_run_d = '0;
          end
        end
        StLock: begin
          // Free-run on the prediction so a received error is not fed back.
          sr_d = {sr_q[5:0], pred};
          if (bit_count_q != '1) bit_count_d = bit_count_q + CNT_W'(1);
          if (!hit) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
            if (miss_run_q == MissLast) begin
              state_d    = StFill;
              fill_cnt_d = 3'd0;
              miss_run_d = '0;
            end else begin
              miss_run_d = miss_run_q + MissW'(1);
            end
          end else begin
            miss_run_d = '0;
          end
        end
        default: state_d = StFill;
      endcase
    end

    if (clear) begin
      err_count_d = '0;
      bit_count_d = '0;
    end

    locked_d = (state_d == StLock);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StFill;
      sr_q        <= 7'h00;
      fill_cnt_q  <= 3'd0;
      match_run_q <= '0;
      miss_run_q  <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      fill_cnt_q  <= fill_cnt_d;
      match_run_q <= match_run_d;
      miss_run_q  <= miss_run_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: a 16-bit and a 4-bit counter instance share stimulus.
module tb_prbs7_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count, bit_count;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s, bit_count_s;

  logic [6:0]  gen_sr;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  prbs7_checker #(.LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_W(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .bit_count (bit_count)
  );

  prbs7_checker #(.LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_W(4)) u_dut_small (
    .clk       (clk),
    .rst       (rst),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .clear     (clear),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s),
    .bit_count (bit_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge; return 1 ns after the sampling edge.
  task automatic step(input logic v, input logic b, input logic c);
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic gen_next(output logic b);
    b      = ~(gen_sr[6] ^ gen_sr[5]);
    gen_sr = {gen_sr[5:0], b};
  endtask

  task automatic good_bit();
    logic b;
    gen_next(b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic bad_bit(input logic c);
    logic b;
    gen_next(b);
    step(1'b1, ~b, c);
  endtask

  task automatic good_bits(input int n);
    for (int i = 0; i < n; i++) good_bit();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    bit_valid = 1'b0;
    clear     = 1'b0;
    @(negedge clk);
    rst    = 1'b0;
    gen_sr = 7'h00;
  endtask

  initial begin
    gen_sr = 7'h00;
    #2;
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err", {16'd0, err_count}, 32'd0);
    check("rst_bits", {16'd0, bit_count}, 32'd0);
    do_reset();

    // Clean lock after 23 valid bits.
    good_bits(22);
    check("lock_22", {31'd0, locked}, 32'd0);
    good_bit();
    check("lock_23", {31'd0, locked}, 32'd1);
    good_bits(7);
    check("bits_30", {16'd0, bit_count}, 32'd7);
    check("err_30", {16'd0, err_count}, 32'd0);

    // Single error.
    bad_bit(1'b0);
    check("single_pulse", {31'd0, err_pulse}, 32'd1);
    check("single_err", {16'd0, err_count}, 32'd1);
    check("single_lock", {31'd0, locked}, 32'd1);
    good_bit();
    check("single_pulse_off", {31'd0, err_pulse}, 32'd0);
    good_bits(10);
    check("single_err_after", {16'd0, err_count}, 32'd1);
    check("single_bits", {16'd0, bit_count}, 32'd19);

    // Clear while idle keeps lock.
    step(1'b0, 1'b0, 1'b1);
    check("clr_err", {16'd0, err_count}, 32'd0);
    check("clr_bits", {16'd0, bit_count}, 32'd0);
    check("clr_lock", {31'd0, locked}, 32'd1);

    // Loss of lock after 4 consecutive errors, back-to-back pulses.
    for (int i = 0; i < 4; i++) begin
      bad_bit(1'b0);
      check("loss_pulse", {31'd0, err_pulse}, 32'd1);
      check("loss_lock", {31'd0, locked}, (i < 3) ? 32'd1 : 32'd0);
    end
    check("loss_err", {16'd0, err_count}, 32'd4);
    good_bit();
    check("loss_pulse_off", {31'd0, err_pulse}, 32'd0);
    good_bits(21);
    check("relock_22", {31'd0, locked}, 32'd0);
    good_bit();
    check("relock_23", {31'd0, locked}, 32'd1);
    check("relock_err", {16'd0, err_count}, 32'd4);

    // Gaps: invalid cycles carry garbage and must change nothing.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      good_bit();
      step(1'b0, ~bit_in, 1'b0);
    end
    check("gap_22", {31'd0, locked}, 32'd0);
    good_bit();
    check("gap_23", {31'd0, locked}, 32'd1);
    good_bits(3);
    check("gap_bits", {16'd0, bit_count}, 32'd3);
    bad_bit(1'b1);
    check("clr_pri_err", {16'd0, err_count}, 32'd0);
    check("clr_pri_bits", {16'd0, bit_count}, 32'd0);
    good_bit();
    check("clr_pri_next", {16'd0, bit_count}, 32'd1);

    // Lockup rejection.
    do_reset();
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b0);
    check("lockup_lock", {31'd0, locked}, 32'd0);
    check("lockup_err", {16'd0, err_count}, 32'd0);

    // Saturation on the 4-bit instance.
    do_reset();
    good_bits(23);
    check("sat_lock", {31'd0, locked_s}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      bad_bit(1'b0);
      good_bits(4);
    end
    check("sat_err_small", {28'd0, err_count_s}, 32'd15);
    check("sat_bits_small", {28'd0, bit_count_s}, 32'd15);
    check("sat_err_wide", {16'd0, err_count}, 32'd20);
    check("sat_bits_wide", {16'd0, bit_count}, 32'd100);
    check("sat_still_lock", {31'd0, locked}, 32'd1);

    // Asynchronous reset mid-stream, checked before any rising edge.
    bad_bit(1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_lock", {31'd0, locked}, 32'd0);
    check("arst_pulse", {31'd0, err_pulse}, 32'd0);
    check("arst_err", {16'd0, err_count}, 32'd0);
    check("arst_bits", {16'd0, bit_count}, 32'd0);
    check("arst_err_small", {28'd0, err_count_s}, 32'd0);
    check("arst_lock_small", {31'd0, locked_s}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
